operand_encoder: RTL and testbench
==================================

# operand_encoder

Multi-cycle encoder that converts a 32-bit constant into ARM operand fields. Its output is the field format the datapath shifter decodes. In data-processing mode it searches for a 12-bit rotated-immediate field {rotate[3:0], imm8[7:0]} whose value equals ROR(imm8, 2·rotate). In branch mode it converts a byte offset into a 24-bit word-offset field. It sits in the instruction-build path ahead of instruction memory and is driven by a start/done handshake.

## Interface
- ROT_STEPS, 16: rotate candidates searched (fixed at 16; not meant to be overridden)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request strobe; sampled on the rising edge, accepted only when not busy
- mode  input  1  0 = rotated immediate, 1 = branch offset
- value  input  32  constant (mode 0) or signed byte offset (mode 1); captured on accept
- busy  output  1  high while in SEARCH
- done  output  1  one-cycle completion pulse
- ok  output  1  1 = value encodable; valid from done onward
- data12Out  output  12  {rotate, imm8}; mode 0 result
- branchOffset  output  24  signed word offset; mode 1 result

## Operation
- States: IDLE, SEARCH, DONE. Reset forces IDLE and clears all outputs and internal registers to 0.
- Accept: start=1 in IDLE or DONE.
  - Latch value and mode; clear rot counter.
  - mode 0 → SEARCH. mode 1 → DONE.
- start=1 in SEARCH is ignored. No queueing, and the captured value is not disturbed.
- SEARCH, each cycle at rotation k = rot:
  - Candidate = ROL(value_reg, 2k).
  - If candidate[31:8]==0 → data12Out={k[3:0], candidate[7:0]}, ok=1, go to DONE.
  - Else if k==15 → data12Out=0, ok=0, go to DONE.
  - Else rot=k+1.
- The smallest k that hits is reported. This makes encoding canonical: value 0 gives 0x000.
- Branch, evaluated on the accept edge, from value:
  - If value[1:0]!=0 → ok=0 (misaligned).
  - Else if value[31:25] is not all equal to value[25] → ok=0 (out of range −2^25..2^25−4).
  - Else ok=1 and branchOffset=value[25:2].
  - On ok=0, branchOffset is 0.
- Output update rules:
  - Mode 0 leaves branchOffset unchanged; mode 1 leaves data12Out unchanged.
  - On accept, ok clears to 0.
  - Result outputs hold their values until the next accept or reset.
- DONE: done=1 for exactly that cycle.
  - Without start, return to IDLE.
  - With start, accept the new request (back-to-back operation).
- busy=1 exactly in SEARCH.

## Timing
- Cycle 0 is the cycle in which start is sampled high.
- Mode 0, hit at rotation k: done=1 in cycle k+2. Best case is cycle 2 (k=0); the unencodable case is cycle 17 (after k=15).
- Mode 1: done=1 in cycle 1.
- data12Out, branchOffset and ok become valid in the same cycle done rises. All outputs are registered.
- Reset asserted mid-search aborts immediately. No done pulse is produced, and the block is in IDLE one edge after reset deasserts.
- start and reset released together: reset wins. start must be held or reasserted after release.

## Test plan
- Reset with start=1, value=0xFFFFFFFF → all outputs 0 during reset; state IDLE; no done.
- Rotated-immediate hits:
  - value=0x000000AB, mode 0 → done in cycle 2, ok=1, data12Out=0x0AB.
  - value=0xFF000000 → done in cycle 6, data12Out=0x4FF.
  - value=0x00000104 → done in cycle 17, data12Out=0xF41.
- Unencodable: value=0x00000102, mode 0 → busy cycles 1–16, done in cycle 17, ok=0, data12Out=0x000.
- Branch mode:
  - value=0x00000008 → done in cycle 1, ok=1, branchOffset=0x000002.
  - value=0xFFFFFFF8 → branchOffset=0xFFFFFE.
  - value=0x00000006 → ok=0.
  - value=0x02000000 → ok=0.
- Handshake:
  - Pulse start with value=0x12 while in SEARCH on 0x104 → ignored; result remains 0xF41.
  - start held high through DONE → next request accepted back-to-back; a single-cycle done pulse per request.
- Reset mid-search: assert reset in cycle 5 of the 0x104 search → busy=0 and done never pulses. A fresh start for 0xAB after release gives 0x0AB in cycle 2.

Source files
------------

// File: rtl/operand_encoder.sv
// rtl/operand_encoder.sv - encodes a 32-bit constant as an ARM rotated immediate or a branch word offset
// A rotated-immediate request walks rotations 0..15 and stops at the first hit; a branch request is checked on the accept edge.
module operand_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        ok,
  output logic [11:0] data12Out,
  output logic [23:0] branchOffset
);

  localparam int ROT_STEPS = 16;
  localparam logic [3:0] LAST_ROT = 4'(ROT_STEPS - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t      state_q;
  logic [31:0] value_q;
  logic [3:0]  rot_q;
  logic        busy_q;
  logic        done_q;
  logic        ok_q;
  logic [11:0] data12_q;
  logic [23:0] branch_q;

  logic [5:0]  shl_amt;
  logic [5:0]  shr_amt;
  logic [31:0] cand;
  logic        cand_hit;
  logic        br_ok;

  // Rotating left by 2k undoes the ROR the shifter applies, so the low byte is the imm8 candidate.
  always_comb begin
    shl_amt  = {1'b0, rot_q, 1'b0};
    shr_amt  = 6'd32 - shl_amt;
    cand     = (value_q << shl_amt) | (value_q >> shr_amt);
    cand_hit = (cand[31:8] == 24'd0);
  end

  // Word aligned, and bits 31:25 all copies of bit 25 so the offset fits in 24 signed bits.
  assign br_ok = (value[1:0] == 2'b00) && (value[31:25] == {7{value[25]}});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      value_q  <= 32'd0;
      rot_q    <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      data12_q <= 12'd0;
      branch_q <= 24'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            value_q <= value;
            rot_q   <= 4'd0;
            if (!mode) begin
              ok_q    <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= SEARCH;
            end else begin
              ok_q     <= br_ok;
              branch_q <= br_ok ? value[25:2] : 24'd0;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= DONE;
            end
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SEARCH: begin
          if (cand_hit) begin
            data12_q <= {rot_q, cand[7:0]};
            ok_q     <= 1'b1;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end else if (rot_q == LAST_ROT) begin
            data12_q <= 12'd0;
            ok_q     <= 1'b0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end else begin
            rot_q <= rot_q + 4'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign ok           = ok_q;
  assign data12Out    = data12_q;
  assign branchOffset = branch_q;

endmodule

// File: tb/tb_operand_encoder.sv
// tb/tb_operand_encoder.sv - directed vector bench for operand_encoder
// Inputs are driven and outputs sampled on the falling edge; cycle 1 is the cycle after start is accepted.
module tb_operand_encoder;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        ok;
  logic [11:0] data12Out;
  logic [23:0] branchOffset;

  int passed;
  int total;

  operand_encoder dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mode         (mode),
    .value        (value),
    .busy         (busy),
    .done         (done),
    .ok           (ok),
    .data12Out    (data12Out),
    .branchOffset (branchOffset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [31:0] v;
    int          cyc;
    logic        ok;
    logic [11:0] d12;
    logic [23:0] br;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic start_req(input logic m, input logic [31:0] v);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    value = v;
    @(negedge clk);
    start = 1'b0;
    value = 32'd0;
  endtask

  // Called at the falling edge of cycle c0; returns the cycle done was seen (99 on timeout).
  task automatic wait_done(input int c0, output int cyc, output int bcnt);
    int c;
    c    = c0;
    bcnt = 0;
    cyc  = 99;
    while (c <= 40) begin
      if (done) begin
        cyc = c;
        break;
      end
      if (busy) bcnt++;
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    int cyc;
    int bcnt;
    passed = 0;
    total  = 0;

    vecs[0]  = '{1'b0, 32'h0000_00AB,  2, 1'b1, 12'h0AB, 24'h000000};
    vecs[1]  = '{1'b0, 32'hFF00_0000,  6, 1'b1, 12'h4FF, 24'h000000};
    vecs[2]  = '{1'b0, 32'h0000_0104, 17, 1'b1, 12'hF41, 24'h000000};
    vecs[3]  = '{1'b0, 32'h0000_0102, 17, 1'b0, 12'h000, 24'h000000};
    vecs[4]  = '{1'b1, 32'h0000_0008,  1, 1'b1, 12'h000, 24'h000002};
    vecs[5]  = '{1'b1, 32'hFFFF_FFF8,  1, 1'b1, 12'h000, 24'hFFFFFE};
    vecs[6]  = '{1'b1, 32'h0000_0006,  1, 1'b0, 12'h000, 24'h000000};
    vecs[7]  = '{1'b1, 32'h0200_0000,  1, 1'b0, 12'h000, 24'h000000};
    vecs[8]  = '{1'b0, 32'h0000_00AB,  2, 1'b1, 12'h0AB, 24'h000000};
    vecs[9]  = '{1'b1, 32'h01FF_FFFC,  1, 1'b1, 12'h0AB, 24'h7FFFFF};
    vecs[10] = '{1'b0, 32'h0000_0000,  2, 1'b1, 12'h000, 24'h7FFFFF};
    vecs[11] = '{1'b1, 32'hFE00_0000,  1, 1'b1, 12'h000, 24'h800000};

    // Reset held with a pending request: everything must stay cleared.
    reset = 1'b0;
    start = 1'b1;
    mode  = 1'b0;
    value = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ok",   {31'd0, ok},   32'd0);
    chk("rst_d12",  {20'd0, data12Out}, 32'd0);
    chk("rst_br",   {8'd0, branchOffset}, 32'd0);
    start = 1'b0;
    value = 32'd0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      start_req(vecs[i].m, vecs[i].v);
      wait_done(1, cyc, bcnt);
      chk($sformatf("v%0d_cycle", i), cyc, vecs[i].cyc);
      chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].cyc - 1);
      chk($sformatf("v%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_ok", i), {31'd0, ok}, {31'd0, vecs[i].ok});
      chk($sformatf("v%0d_d12", i), {20'd0, data12Out}, {20'd0, vecs[i].d12});
      chk($sformatf("v%0d_br", i), {8'd0, branchOffset}, {8'd0, vecs[i].br});
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // A start pulse during SEARCH must not disturb the search in progress.
    start_req(1'b0, 32'h0000_0104);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    value = 32'h0000_0012;
    @(negedge clk);
    start = 1'b0;
    value = 32'd0;
    wait_done(4, cyc, bcnt);
    chk("ign_cycle", cyc, 17);
    chk("ign_d12", {20'd0, data12Out}, 32'h0000_0F41);
    chk("ign_ok", {31'd0, ok}, 32'd1);
    @(negedge clk);

    // Start held through DONE: second request is accepted straight from DONE.
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    value = 32'h0000_00AB;
    @(negedge clk);
    chk("b2b_c1_done", {31'd0, done}, 32'd0);
    chk("b2b_c1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("b2b_c2_done", {31'd0, done}, 32'd1);
    chk("b2b_c2_d12", {20'd0, data12Out}, 32'h0000_00AB);
    value = 32'h0000_00CD;
    @(negedge clk);
    start = 1'b0;
    value = 32'd0;
    chk("b2b_c3_done", {31'd0, done}, 32'd0);
    chk("b2b_c3_busy", {31'd0, busy}, 32'd1);
    chk("b2b_c3_ok", {31'd0, ok}, 32'd0);
    @(negedge clk);
    chk("b2b_c4_done", {31'd0, done}, 32'd1);
    chk("b2b_c4_d12", {20'd0, data12Out}, 32'h0000_00CD);
    @(negedge clk);
    chk("b2b_c5_done", {31'd0, done}, 32'd0);
    chk("b2b_c5_busy", {31'd0, busy}, 32'd0);

    // Reset in cycle 5 of a search aborts it without a done pulse.
    start_req(1'b0, 32'h0000_0104);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) bcnt++;
    end
    chk("abort_quiet", bcnt, 0);
    start_req(1'b0, 32'h0000_00AB);
    wait_done(1, cyc, bcnt);
    chk("fresh_cycle", cyc, 2);
    chk("fresh_d12", {20'd0, data12Out}, 32'h0000_00AB);
    chk("fresh_ok", {31'd0, ok}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
